mem_arbiter: RTL

Two-port arbiter and access sequencer for the shared 64-word unified memory of the single-memory MIPS datapath. It shares the memory between the instruction-fetch requester and the load/store requester with round-robin fairness. It drives the memory's `dir`/`data_input`/`mem_rd`/`mem_wd` strobes for exactly one cycle per access and registers the read data. It also rejects misaligned or out-of-range addresses before they reach the memory.

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter and one-cycle access sequencer for the unified memory
module mem_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h00400000,
    parameter int          DEPTH     = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        dm_err,
    output logic [31:0] dir,
    output logic [31:0] data_input,
    output logic        mem_rd,
    output logic        mem_wd,
    input  logic [31:0] data_output
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    localparam logic [32:0] SPAN = 33'(4 * DEPTH);

    state_t      state, state_next;
    logic        last_dm;
    logic        gnt_dm;
    logic        grant_dm;
    logic        we_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] addr_off;
    logic        addr_ok;

    // Offset compare is widened so BASE_ADDR + 4*DEPTH cannot wrap.
    assign addr_off = addr_q - BASE_ADDR;
    assign addr_ok  = (addr_q[1:0] == 2'b00) && (addr_q >= BASE_ADDR) && ({1'b0, addr_off} < SPAN);

    always_comb begin
        state_next = state;
        grant_dm   = 1'b0;
        case (state)
            IDLE: begin
                if (if_req && dm_req) grant_dm = ~last_dm;
                else                  grant_dm = dm_req;
                if (if_req || dm_req) state_next = ACCESS;
            end
            ACCESS:  state_next = RESPOND;
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    always_comb begin
        mem_rd     = 1'b0;
        mem_wd     = 1'b0;
        dir        = 32'h0;
        data_input = 32'h0;
        if (state == ACCESS && addr_ok) begin
            dir = addr_q;
            if (we_q) begin
                mem_wd     = 1'b1;
                data_input = wdata_q;
            end else begin
                mem_rd = 1'b1;
            end
        end
    end

    assign if_ack = (state == RESPOND) && !gnt_dm;
    assign dm_ack = (state == RESPOND) && gnt_dm;
    assign if_err = if_ack && err_q;
    assign dm_err = dm_ack && err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_dm  <= 1'b1;
            gnt_dm   <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            if_rdata <= 32'h0;
            dm_rdata <= 32'h0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        gnt_dm  <= grant_dm;
                        addr_q  <= grant_dm ? dm_addr : if_addr;
                        we_q    <= grant_dm & dm_we;
                        wdata_q <= grant_dm ? dm_wdata : 32'h0;
                        err_q   <= 1'b0;
                    end
                end
                ACCESS: begin
                    err_q <= ~addr_ok;
                    if (!addr_ok) begin
                        if (gnt_dm) dm_rdata <= 32'h0;
                        else        if_rdata <= 32'h0;
                    end else if (!we_q) begin
                        if (gnt_dm) dm_rdata <= data_output;
                        else        if_rdata <= data_output;
                    end
                end
                RESPOND: last_dm <= gnt_dm;
                default: ;
            endcase
        end
    end

endmodule
